// File: rtl/fetch_queue.sv
// Byte-wide instruction prefetch queue: a circular buffer that streams bytes from
// instruction memory and presents a 4-byte decode window at fetch_eip.
module fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk2,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [31:0] ope,
  output logic        ope_valid,
  output logic [31:0] fetch_eip,
  input  logic        advance,
  input  logic [3:0]  adv_len,
  output logic        adv_err,
  input  logic        redirect,
  input  logic [31:0] redirect_addr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StEmpty, StFill, StFull} state_e;

  state_e          state_q, state_d;
  logic [7:0]      fifo_q [DEPTH];
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     eip_q, eip_d;
  logic            err_q, err_d;

  logic            wr_en;
  logic            len_ok;
  logic            adv_ok;
  logic [CW-1:0]   adv_amt;
  logic [7:0]      lane [4];

  // The FSM mirrors occupancy; FULL is what gates further requests.
  assign mem_req   = !reset && !redirect && (state_q != StFull);
  assign mem_addr  = eip_q + 32'(count_q);
  assign wr_en     = mem_req && mem_ack;
  assign fetch_eip = eip_q;
  assign adv_err   = err_q;
  assign ope_valid = (count_q >= CW'(4));

  always_comb begin
    len_ok  = (adv_len >= 4'd1) && (adv_len <= 4'd6);
    adv_ok  = advance && len_ok && (32'(adv_len) <= 32'(count_q));
    adv_amt = adv_ok ? CW'(adv_len) : '0;

    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    eip_d   = eip_q;
    err_d   = 1'b0;

    if (redirect) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      eip_d   = redirect_addr;
    end else begin
      if (adv_ok) begin
        rptr_d = rptr_q + PW'(adv_len);
        eip_d  = eip_q + 32'(adv_len);
      end else if (advance) begin
        err_d = 1'b1;
      end
      if (wr_en) begin
        wptr_d = wptr_q + PW'(1);
      end
      count_d = count_q + CW'(wr_en) - adv_amt;
    end

    if (count_d == '0) begin
      state_d = StEmpty;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = StFull;
    end else begin
      state_d = StFill;
    end
  end

  always_ff @(posedge clk2) begin
    if (reset) begin
      state_q <= StEmpty;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      eip_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      eip_q   <= eip_d;
      err_q   <= err_d;
    end
  end

  // Storage needs no reset: lanes beyond count are masked in the window.
  always_ff @(posedge clk2) begin
    if (wr_en) begin
      fifo_q[wptr_q] <= mem_data;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane[i] = 8'h00;
      if (CW'(i) < count_q) begin
        lane[i] = fifo_q[rptr_q + PW'(i)];
      end
    end
    ope = {lane[0], lane[1], lane[2], lane[3]};
  end

endmodule
